// File: rtl/trap_sequencer.sv
// trap_sequencer: M-mode trap / mret sequencer owning the CSR write port.
// Latency: trap redirect at N+5 (writes N+1..N+4), mret redirect at N+2; IDLE passthrough is combinational.
// Backpressure: holds stall/trap_busy while sequencing, ignores requests; optional irq via TRAP_SEQ_IRQ_EN.
module trap_sequencer #(
   parameter int DATA_WIDTH     = 32,
   parameter int CSR_ADDR_WIDTH = 12
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_WIDTH-1:0]     pc_in,
   input  logic [DATA_WIDTH-1:0]     instr_in,
   input  logic [DATA_WIDTH-1:0]     fault_addr_in,
   input  logic [4:0]                exc_req,
   input  logic                      irq_ext,
   input  logic                      mret,
   input  logic [DATA_WIDTH-1:0]     mstatus_in,
   input  logic [DATA_WIDTH-1:0]     mie_in,
   input  logic [DATA_WIDTH-1:0]     mtvec_in,
   input  logic [DATA_WIDTH-1:0]     mepc_in,
   input  logic                      pipe_csr_wr,
   input  logic [CSR_ADDR_WIDTH-1:0] pipe_csr_addr,
   input  logic [DATA_WIDTH-1:0]     pipe_csr_data,
   input  logic [1:0]                pipe_csr_cntrl,
   output logic                      csr_wr,
   output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
   output logic [DATA_WIDTH-1:0]     csr_data,
   output logic [1:0]                csr_cntrl,
   output logic                      stall,
   output logic                      flush,
   output logic                      redirect_valid,
   output logic [DATA_WIDTH-1:0]     redirect_pc,
   output logic                      trap_busy
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_W_MEPC    = 3'd1;
   localparam logic [2:0] S_W_MCAUSE  = 3'd2;
   localparam logic [2:0] S_W_MTVAL   = 3'd3;
   localparam logic [2:0] S_W_MSTATUS = 3'd4;
   localparam logic [2:0] S_R_MSTATUS = 3'd5;
   localparam logic [2:0] S_REDIRECT  = 3'd6;

   localparam logic [DATA_WIDTH-1:0] IRQ_CAUSE = {1'b1, {(DATA_WIDTH-5){1'b0}}, 4'hB};

   logic [2:0]            state;
   logic [DATA_WIDTH-1:0] lat_pc, lat_cause, lat_tval, lat_mstatus;
   logic                  lat_mret;

   logic                  exc_any, irq_take, event_take;
   logic [3:0]            exc_code;
   logic [DATA_WIDTH-1:0] exc_tval;
   logic [DATA_WIDTH-1:0] trap_mstatus, mret_mstatus;

   // Only some mie/mtvec bits matter; irq_ext is dead when interrupts are compiled out.
   logic unused_inputs;
   assign unused_inputs = ^{irq_ext, mie_in, mtvec_in[1:0]};

   // Exception priority encode: lowest set index wins; mtval source follows the cause.
   always_comb begin
      exc_any  = |exc_req;
      exc_code = 4'd0;
      exc_tval = '0;
      if (exc_req[0]) begin
         exc_code = 4'd3;
      end else if (exc_req[1]) begin
         exc_code = 4'd0;
         exc_tval = fault_addr_in;
      end else if (exc_req[2]) begin
         exc_code = 4'd2;
         exc_tval = instr_in;
      end else if (exc_req[3]) begin
         exc_code = 4'd11;
      end else if (exc_req[4]) begin
         exc_code = 4'd4;
         exc_tval = fault_addr_in;
      end
   end

`ifdef TRAP_SEQ_IRQ_EN
   assign irq_take = irq_ext & mstatus_in[3] & mie_in[11] & ~exc_any;
`else
   assign irq_take = 1'b0;
`endif

   assign event_take = exc_any | irq_take | mret;

   // mstatus images written on trap entry and on mret.
   always_comb begin
      trap_mstatus        = lat_mstatus;
      trap_mstatus[7]     = lat_mstatus[3];
      trap_mstatus[3]     = 1'b0;
      trap_mstatus[12:11] = 2'b11;
      mret_mstatus        = lat_mstatus;
      mret_mstatus[3]     = lat_mstatus[7];
      mret_mstatus[7]     = 1'b1;
   end

   // Sequence state and event latches; reset abandons any sequence in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         lat_pc      <= '0;
         lat_cause   <= '0;
         lat_tval    <= '0;
         lat_mstatus <= '0;
         lat_mret    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (exc_any || irq_take) begin
                  state       <= S_W_MEPC;
                  lat_pc      <= pc_in;
                  lat_cause   <= irq_take ? IRQ_CAUSE : DATA_WIDTH'(exc_code);
                  lat_tval    <= exc_tval;
                  lat_mstatus <= mstatus_in;
                  lat_mret    <= 1'b0;
               end else if (mret) begin
                  state       <= S_R_MSTATUS;
                  lat_mstatus <= mstatus_in;
                  lat_mret    <= 1'b1;
               end
            end
            S_W_MEPC:    state <= S_W_MCAUSE;
            S_W_MCAUSE:  state <= S_W_MTVAL;
            S_W_MTVAL:   state <= S_W_MSTATUS;
            S_W_MSTATUS: state <= S_REDIRECT;
            S_R_MSTATUS: state <= S_REDIRECT;
            default:     state <= S_IDLE;
         endcase
      end
   end

   // Output decode: passthrough in IDLE (dropped on an accepted event), sequence writes otherwise.
   always_comb begin
      csr_wr         = 1'b0;
      csr_addr       = '0;
      csr_data       = '0;
      csr_cntrl      = 2'b00;
      stall          = 1'b0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      trap_busy      = 1'b0;
      if (!reset) begin
         case (state)
            S_IDLE: begin
               if (!event_take) begin
                  csr_wr    = pipe_csr_wr;
                  csr_addr  = pipe_csr_addr;
                  csr_data  = pipe_csr_data;
                  csr_cntrl = pipe_csr_cntrl;
               end
            end
            S_W_MEPC: begin
               csr_wr   = 1'b1;
               csr_addr = CSR_ADDR_WIDTH'(12'h341);
               csr_data = lat_pc;
               flush    = 1'b1;
            end
            S_W_MCAUSE: begin
               csr_wr   = 1'b1;
               csr_addr = CSR_ADDR_WIDTH'(12'h342);
               csr_data = lat_cause;
            end
            S_W_MTVAL: begin
               csr_wr   = 1'b1;
               csr_addr = CSR_ADDR_WIDTH'(12'h343);
               csr_data = lat_tval;
            end
            S_W_MSTATUS: begin
               csr_wr   = 1'b1;
               csr_addr = CSR_ADDR_WIDTH'(12'h300);
               csr_data = trap_mstatus;
            end
            S_R_MSTATUS: begin
               csr_wr   = 1'b1;
               csr_addr = CSR_ADDR_WIDTH'(12'h300);
               csr_data = mret_mstatus;
               flush    = 1'b1;
            end
            S_REDIRECT: begin
               redirect_valid = 1'b1;
               redirect_pc    = lat_mret ? mepc_in : {mtvec_in[DATA_WIDTH-1:2], 2'b00};
            end
            default: ;
         endcase
         if (state != S_IDLE) begin
            stall     = 1'b1;
            trap_busy = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: table of IDLE vectors plus hand-built trap/mret/reset sequences.
// Expected per-cycle outputs are queued when stimulus is driven and popped when sampled.
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in, instr_in, fault_addr_in;
   logic [4:0]  exc_req;
   logic        irq_ext, mret;
   logic [31:0] mstatus_in, mie_in, mtvec_in, mepc_in;
   logic        pipe_csr_wr;
   logic [11:0] pipe_csr_addr;
   logic [31:0] pipe_csr_data;
   logic [1:0]  pipe_csr_cntrl;
   logic        csr_wr;
   logic [11:0] csr_addr;
   logic [31:0] csr_data;
   logic [1:0]  csr_cntrl;
   logic        stall, flush, redirect_valid, trap_busy;
   logic [31:0] redirect_pc;

   trap_sequencer #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) dut (
      .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
      .fault_addr_in(fault_addr_in), .exc_req(exc_req), .irq_ext(irq_ext), .mret(mret),
      .mstatus_in(mstatus_in), .mie_in(mie_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
      .pipe_csr_wr(pipe_csr_wr), .pipe_csr_addr(pipe_csr_addr), .pipe_csr_data(pipe_csr_data),
      .pipe_csr_cntrl(pipe_csr_cntrl), .csr_wr(csr_wr), .csr_addr(csr_addr), .csr_data(csr_data),
      .csr_cntrl(csr_cntrl), .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .trap_busy(trap_busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] data;
      logic [1:0]  cntrl;
      logic        stall;
      logic        flush;
      logic        rv;
      logic [31:0] rpc;
      logic        busy;
   } out_t;

   typedef struct {
      out_t  o;
      string nm;
   } exp_t;

   typedef struct {
      string       nm;
      logic        pwr;
      logic [11:0] pa;
      logic [31:0] pd;
      logic [1:0]  pc;
      logic        irq;
      logic [31:0] mst;
      logic [31:0] mie;
      out_t        exp;
   } vec_t;

   exp_t sb_q[$];
   vec_t vt[$];
   int   vectors = 0;
   int   miscompares = 0;

   function automatic out_t o_zero();
      return '0;
   endfunction

   function automatic out_t o_pass(logic w, logic [11:0] a, logic [31:0] d, logic [1:0] c);
      out_t o = '0;
      o.wr = w; o.addr = a; o.data = d; o.cntrl = c;
      return o;
   endfunction

   function automatic out_t o_seqwr(logic [11:0] a, logic [31:0] d, logic fl);
      out_t o = '0;
      o.wr = 1'b1; o.addr = a; o.data = d; o.stall = 1'b1; o.flush = fl; o.busy = 1'b1;
      return o;
   endfunction

   function automatic out_t o_redir(logic [31:0] pc);
      out_t o = '0;
      o.rv = 1'b1; o.rpc = pc; o.stall = 1'b1; o.busy = 1'b1;
      return o;
   endfunction

   task automatic push(out_t o, string nm);
      exp_t e;
      e.o = o; e.nm = nm;
      sb_q.push_back(e);
   endtask

   // Sample 2 time units after the negedge input update, well away from the posedge.
   task automatic check_cycle();
      exp_t e;
      out_t a;
      #2;
      a = {csr_wr, csr_addr, csr_data, csr_cntrl, stall, flush, redirect_valid, redirect_pc, trap_busy};
      vectors++;
      if (sb_q.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty: no expected entry for outputs %h", a);
         return;
      end
      e = sb_q.pop_front();
      if (a !== e.o) begin
         miscompares++;
         $display("FAIL %s: actual wr=%0b addr=%h data=%h cntrl=%0d stall=%0b flush=%0b rv=%0b rpc=%h busy=%0b | required wr=%0b addr=%h data=%h cntrl=%0d stall=%0b flush=%0b rv=%0b rpc=%h busy=%0b",
                  e.nm, a.wr, a.addr, a.data, a.cntrl, a.stall, a.flush, a.rv, a.rpc, a.busy,
                  e.o.wr, e.o.addr, e.o.data, e.o.cntrl, e.o.stall, e.o.flush, e.o.rv, e.o.rpc, e.o.busy);
      end
   endtask

   task automatic idle_inputs();
      pc_in = 0; instr_in = 0; fault_addr_in = 0; exc_req = 0; irq_ext = 0; mret = 0;
      mstatus_in = 0; mie_in = 0;
      pipe_csr_wr = 0; pipe_csr_addr = 0; pipe_csr_data = 0; pipe_csr_cntrl = 0;
   endtask

   // Requests presented while busy must be ignored.
   task automatic busy_noise();
      exc_req = 5'h1F; mret = 1'b1; irq_ext = 1'b1; pc_in = 32'hBAD0;
      instr_in = 32'h1234; mstatus_in = 32'hFFFF; mie_in = 32'hFFFF;
      pipe_csr_wr = 1'b1; pipe_csr_addr = 12'h7FF; pipe_csr_data = 32'hDEAD; pipe_csr_cntrl = 2'b01;
   endtask

   task automatic do_trap(string nm, logic [4:0] exc, logic irq, logic [31:0] pc, logic [31:0] instr,
                          logic [31:0] fault, logic [31:0] mst, logic [31:0] mie, logic [31:0] mtvec,
                          logic pwr, logic [31:0] cause, logic [31:0] tval, logic [31:0] mst_w,
                          logic [31:0] rpc);
      @(negedge clk);
      idle_inputs();
      exc_req = exc; irq_ext = irq; pc_in = pc; instr_in = instr; fault_addr_in = fault;
      mstatus_in = mst; mie_in = mie; mtvec_in = mtvec;
      pipe_csr_wr = pwr; pipe_csr_addr = 12'h305; pipe_csr_data = 32'h77; pipe_csr_cntrl = 2'b00;
      push(o_zero(), {nm, "_accept"});
      check_cycle();
      push(o_seqwr(12'h341, pc, 1'b1), {nm, "_mepc"});
      push(o_seqwr(12'h342, cause, 1'b0), {nm, "_mcause"});
      push(o_seqwr(12'h343, tval, 1'b0), {nm, "_mtval"});
      push(o_seqwr(12'h300, mst_w, 1'b0), {nm, "_mstatus"});
      push(o_redir(rpc), {nm, "_redirect"});
      push(o_zero(), {nm, "_idle"});
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (i < 6) busy_noise(); else idle_inputs();
         check_cycle();
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      mtvec_in = 0; mepc_in = 0;

      vt.push_back('{"pass_set",   1'b1, 12'h304, 32'h800,  2'b01, 1'b0, 32'h0, 32'h0,   o_pass(1'b1, 12'h304, 32'h800, 2'b01)});
      vt.push_back('{"pass_write", 1'b1, 12'h305, 32'h100,  2'b00, 1'b0, 32'h0, 32'h0,   o_pass(1'b1, 12'h305, 32'h100, 2'b00)});
      vt.push_back('{"pass_clear", 1'b1, 12'h300, 32'h8,    2'b10, 1'b0, 32'h0, 32'h0,   o_pass(1'b1, 12'h300, 32'h8, 2'b10)});
      vt.push_back('{"pass_nowr",  1'b0, 12'h341, 32'hABCD, 2'b00, 1'b0, 32'h0, 32'h0,   o_pass(1'b0, 12'h341, 32'hABCD, 2'b00)});
      vt.push_back('{"irq_mie_off",1'b1, 12'h340, 32'h5,    2'b00, 1'b1, 32'h8, 32'h0,   o_pass(1'b1, 12'h340, 32'h5, 2'b00)});
      vt.push_back('{"irq_mie_gl", 1'b1, 12'h340, 32'h6,    2'b00, 1'b1, 32'h0, 32'h800, o_pass(1'b1, 12'h340, 32'h6, 2'b00)});
`ifndef TRAP_SEQ_IRQ_EN
      vt.push_back('{"irq_disabled",1'b1,12'h304, 32'h800,  2'b01, 1'b1, 32'h8, 32'h800, o_pass(1'b1, 12'h304, 32'h800, 2'b01)});
`endif

      // Reset state: outputs held at zero even with a pipeline write presented.
      @(negedge clk);
      pipe_csr_wr = 1'b1; pipe_csr_addr = 12'h304; pipe_csr_data = 32'h800; pipe_csr_cntrl = 2'b01;
      push(o_zero(), "reset_state");
      check_cycle();
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      push(o_zero(), "post_reset_idle");
      check_cycle();

      // IDLE vectors from the table.
      foreach (vt[i]) begin
         @(negedge clk);
         idle_inputs();
         pipe_csr_wr = vt[i].pwr; pipe_csr_addr = vt[i].pa; pipe_csr_data = vt[i].pd;
         pipe_csr_cntrl = vt[i].pc; irq_ext = vt[i].irq; mstatus_in = vt[i].mst; mie_in = vt[i].mie;
         push(vt[i].exp, vt[i].nm);
         check_cycle();
      end

      do_trap("illegal", 5'b00100, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0, 32'h8, 32'h0, 32'h203,
              1'b0, 32'h2, 32'hFFFFFFFF, 32'h1880, 32'h200);
      do_trap("multi", 5'b11001, 1'b1, 32'h180, 32'h13, 32'h44, 32'h8, 32'h800, 32'h400,
              1'b1, 32'h3, 32'h0, 32'h1880, 32'h400);
      do_trap("imisalign", 5'b00010, 1'b0, 32'h222, 32'h13, 32'h123, 32'h0, 32'h0, 32'h500,
              1'b1, 32'h0, 32'h123, 32'h1800, 32'h500);
      do_trap("lsmisalign", 5'b10000, 1'b0, 32'h300, 32'h13, 32'h55, 32'h88, 32'h0, 32'h601,
              1'b0, 32'h4, 32'h55, 32'h1880, 32'h600);
      do_trap("ill_vs_ecall", 5'b01100, 1'b0, 32'h340, 32'h0BAD0073, 32'h99, 32'h0, 32'h0, 32'h700,
              1'b0, 32'h2, 32'h0BAD0073, 32'h1800, 32'h700);
`ifdef TRAP_SEQ_IRQ_EN
      do_trap("irq", 5'b00000, 1'b1, 32'h400, 32'h13, 32'h0, 32'h8, 32'h800, 32'h300,
              1'b1, 32'h8000000B, 32'h0, 32'h1880, 32'h300);
`endif

      // mret: mstatus restore then redirect to mepc.
      @(negedge clk);
      idle_inputs();
      mret = 1'b1; mstatus_in = 32'h1880; mepc_in = 32'h104;
      pipe_csr_wr = 1'b1; pipe_csr_addr = 12'h305; pipe_csr_data = 32'h1;
      push(o_zero(), "mret_accept");
      check_cycle();
      push(o_seqwr(12'h300, 32'h1888, 1'b1), "mret_mstatus");
      push(o_redir(32'h104), "mret_redirect");
      push(o_zero(), "mret_idle");
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         if (i < 3) busy_noise(); else idle_inputs();
         check_cycle();
      end

      // Reset in W_MTVAL: outputs drop, no redirect, next exception accepted normally.
      @(negedge clk);
      idle_inputs();
      exc_req = 5'b00100; pc_in = 32'h900; instr_in = 32'hCAFE; mstatus_in = 32'h8; mtvec_in = 32'h800;
      push(o_zero(), "rst_accept");
      check_cycle();
      push(o_seqwr(12'h341, 32'h900, 1'b1), "rst_mepc");
      push(o_seqwr(12'h342, 32'h2, 1'b0), "rst_mcause");
      push(o_seqwr(12'h343, 32'hCAFE, 1'b0), "rst_mtval");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         busy_noise();
         check_cycle();
      end
      #1 reset = 1'b1;
      push(o_zero(), "rst_async_zero");
      check_cycle();
      @(negedge clk);
      push(o_zero(), "rst_held");
      check_cycle();
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         push(o_zero(), "rst_no_redirect");
         check_cycle();
      end
      do_trap("after_rst", 5'b01000, 1'b0, 32'hA00, 32'h73, 32'h0, 32'h0, 32'h0, 32'hB00,
              1'b1, 32'hB, 32'h0, 32'h1800, 32'hB00);

      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover: actual %0d entries, required 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
